txuart_arbiter: RTL

Round-robin arbiter sharing one `txuart`/`txuartlite` transmitter between NREQ byte-stream requesters. A grant locks to one requester for a whole message, terminated by a `last`-flagged byte, so messages from different sources never interleave on the serial line. It sits between the on-chip byte sources (echo path, debug console, status reporter) and the transmitter's `i_wr`/`i_data`/`o_busy` port.

---
 rtl/txuart_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/txuart_arbiter.sv
// -----------------------------------------------------------------------------
// txuart_arbiter
//
// Round-robin arbiter that shares one txuart/txuartlite transmitter between
// NREQ byte-stream requesters. Once a requester is granted it owns the
// transmitter until it hands over a byte flagged "last", so messages from
// different sources never interleave on the serial line.
//
// Optional feature macro: TXARB_TIMEOUT_EN
//   When defined, an owner whose strobe stays low for TIMEOUT consecutive
//   cycles loses its grant. When undefined, only a last-flagged transfer
//   releases the grant and TIMEOUT/LGTIMEOUT have no effect.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   LGTIMEOUT  width of the stall counter
//   TIMEOUT    idle cycles before a stalled grant is revoked
//
// Ports
//   i_clk        system clock
//   i_areset_n   asynchronous active-low reset
//   i_req_stb    [NREQ]    requester n presents a byte
//   i_req_data   [8*NREQ]  byte of requester n in bits [8n+7:8n]
//   i_req_last   [NREQ]    byte is the final byte of requester n's message
//   o_req_busy   [NREQ]    requester n must hold its byte
//   o_tx_stb               write strobe to transmitter i_wr
//   o_tx_data    [8]       byte to transmitter i_data
//   i_tx_busy              transmitter o_busy
//   o_grant      [NREQ]    one-hot current owner, zero when idle
// -----------------------------------------------------------------------------
module txuart_arbiter #(
  parameter int unsigned          NREQ      = 2,
  parameter int unsigned          LGTIMEOUT = 24,
  parameter logic [LGTIMEOUT-1:0] TIMEOUT   = LGTIMEOUT'(86800)
) (
  input  logic                i_clk,
  input  logic                i_areset_n,
  input  logic [NREQ-1:0]     i_req_stb,
  input  logic [8*NREQ-1:0]   i_req_data,
  input  logic [NREQ-1:0]     i_req_last,
  output logic [NREQ-1:0]     o_req_busy,
  output logic                o_tx_stb,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_busy,
  output logic [NREQ-1:0]     o_grant
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   rr_ptr_q;

  // Arbitration and owner-path signals
  logic [NREQ-1:0] stb_rot;
  logic [PW:0]     pick_sum;
  logic [PW-1:0]   pick_d;
  logic            pick_valid_d;
  logic [PW-1:0]   rr_next_d;
  logic            owner_stb;
  logic            owner_last;
  logic            xfer;
  logic            release_d;
  logic            tmo_hit;
  logic [7:0]      tx_data_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick. The request vector is rotated so that bit 0 is the
  // requester at rr_ptr; the lowest set bit of the rotated vector is the
  // winner. Scanning from the top down lets the last hit (lowest offset) win
  // without needing a loop exit.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    stb_rot      = NREQ'({i_req_stb, i_req_stb} >> rr_ptr_q);
    pick_valid_d = |i_req_stb;
    pick_sum     = '0;
    pick_d       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (stb_rot[i]) begin
        pick_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
        if (pick_sum >= (PW+1)'(NREQ)) begin
          pick_sum = pick_sum - (PW+1)'(NREQ);
        end
        pick_d = pick_sum[PW-1:0];
      end
    end
  end

  // Pointer value used when the current owner releases: one past the owner.
  assign rr_next_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  // ---------------------------------------------------------------------------
  // Owner pass-through. grant_q is zero in IDLE, which forces the strobe and
  // data to zero and every busy bit to one without looking at the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_data_d = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        tx_data_d = tx_data_d | i_req_data[8*i +: 8];
      end
    end
  end

  assign owner_stb  = |(i_req_stb & grant_q);
  assign owner_last = |(i_req_last & grant_q);
  assign xfer       = owner_stb & ~i_tx_busy;

  assign o_tx_stb   = owner_stb;
  assign o_tx_data  = tx_data_d;
  assign o_req_busy = ~grant_q | {NREQ{i_tx_busy}};
  assign o_grant    = grant_q;

  // ---------------------------------------------------------------------------
  // Stall timeout (optional)
  // ---------------------------------------------------------------------------
`ifdef TXARB_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] tmo_q;

  // Fires on the idle cycle that would take the counter past TIMEOUT-1.
  // The owner strobe is low here, so it can never coincide with a transfer.
  assign tmo_hit = (state_q == ST_LOCKED) && !owner_stb &&
                   (tmo_q == TIMEOUT - LGTIMEOUT'(1));

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      tmo_q <= '0;
    end else if ((state_q != ST_LOCKED) || owner_stb || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + LGTIMEOUT'(1);
    end
  end
`else
  // No counter: a grant is only released by a last-flagged transfer.
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  assign release_d = (xfer && owner_last) || tmo_hit;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d) begin
            state_q <= ST_LOCKED;
            grant_q <= NREQ'(1) << pick_d;
            owner_q <= pick_d;
          end
        end
        ST_LOCKED: begin
          // Non-owner inputs never reach here; only the owner can release.
          if (release_d) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_next_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
